// File: rtl/throttle_controller.sv
// Arming, watchdog failsafe and slew-rate limiter between the DShot decoder and pwmout.
// target_speed only moves at PWM period boundaries once the block is armed.
module throttle_controller #(
  parameter int ARM_FRAMES     = 10,
  parameter int TIMEOUT_CYCLES = 160000,
  parameter int SLEW_CYCLES    = 6400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_valid,
  input  logic       frame_crc_ok,
  input  logic [7:0] frame_throttle,
  input  logic       pwm_period_start,
  output logic [7:0] target_speed,
  output logic       armed,
  output logic       failsafe,
  output logic [1:0] state
);

  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(SLEW_CYCLES + 1);
  localparam int AW = $clog2(ARM_FRAMES + 1);
  localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_EXPIRE  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0] SLEW_LAST  = SW'(SLEW_CYCLES - 1);
  localparam logic [AW-1:0] ARM_TARGET = AW'(ARM_FRAMES);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMING   = 2'b01,
    ARMED    = 2'b10,
    FAILSAFE = 2'b11
  } state_t;

  state_t        cur_state, next_state;
  logic [WW-1:0] wd_cnt;
  logic [SW-1:0] slew_cnt;
  logic [AW-1:0] arm_cnt, arm_cnt_n, arm_cnt_inc;
  logic [7:0]    cmd, cmd_n, ramp, ramp_n;
  logic          good_frame, zero_frame, timeout, tick;

  assign good_frame  = frame_valid & frame_crc_ok;
  assign zero_frame  = (frame_throttle == 8'd0);
  assign timeout     = (wd_cnt >= WD_EXPIRE);
  assign tick        = (slew_cnt == SLEW_LAST);
  assign arm_cnt_inc = arm_cnt + AW'(1);
  assign state       = cur_state;

  // A good frame always takes precedence over a coincident timeout.
  always_comb begin
    next_state = cur_state;
    cmd_n      = cmd;
    ramp_n     = ramp;
    arm_cnt_n  = arm_cnt;
    case (cur_state)
      DISARMED: begin
        cmd_n     = 8'd0;
        ramp_n    = 8'd0;
        arm_cnt_n = '0;
        if (good_frame && zero_frame) begin
          next_state = ARMING;
          arm_cnt_n  = AW'(1);
        end
      end
      ARMING: begin
        cmd_n  = 8'd0;
        ramp_n = 8'd0;
        if (good_frame) begin
          if (zero_frame) begin
            arm_cnt_n = arm_cnt_inc;
            if (arm_cnt_inc == ARM_TARGET) next_state = ARMED;
          end else begin
            next_state = DISARMED;
            arm_cnt_n  = '0;
          end
        end else if (timeout) begin
          next_state = DISARMED;
          arm_cnt_n  = '0;
        end
      end
      ARMED: begin
        arm_cnt_n = '0;
        if (good_frame) cmd_n = frame_throttle;
        if (cmd < ramp)              ramp_n = cmd;
        else if (tick && cmd > ramp) ramp_n = ramp + 8'd1;
        if (!good_frame && timeout) next_state = FAILSAFE;
      end
      default: begin
        cmd_n     = 8'd0;
        arm_cnt_n = '0;
        if (tick && ramp != 8'd0) ramp_n = ramp - 8'd1;
        if (good_frame && zero_frame && ramp == 8'd0) next_state = DISARMED;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state    <= DISARMED;
      wd_cnt       <= '0;
      slew_cnt     <= '0;
      arm_cnt      <= '0;
      cmd          <= 8'd0;
      ramp         <= 8'd0;
      target_speed <= 8'd0;
      armed        <= 1'b0;
      failsafe     <= 1'b0;
    end else begin
      cur_state <= next_state;
      arm_cnt   <= arm_cnt_n;
      cmd       <= cmd_n;
      ramp      <= ramp_n;
      armed     <= (next_state == ARMED);
      failsafe  <= (next_state == FAILSAFE);
      if (good_frame)             wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)  wd_cnt <= wd_cnt + WW'(1);
      if (tick) slew_cnt <= '0;
      else      slew_cnt <= slew_cnt + SW'(1);
      // Sample the pre-update ramp so pwmout sees a whole-period-stable duty.
      if (next_state == DISARMED || next_state == ARMING) target_speed <= 8'd0;
      else if (pwm_period_start)                          target_speed <= ramp;
    end
  end

endmodule

// File: tb/tb_throttle_controller.sv
// Directed bench for throttle_controller with ARM_FRAMES=3, TIMEOUT_CYCLES=100, SLEW_CYCLES=4
// and a PWM period start every 8 cycles.
module tb_throttle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_valid;
  logic       frame_crc_ok;
  logic [7:0] frame_throttle;
  logic       pwm_period_start;
  logic [7:0] target_speed;
  logic       armed;
  logic       failsafe;
  logic [1:0] state;

  int   check_cnt = 0;
  int   error_cnt = 0;
  int   cyc = 0;
  logic pwm_at_edge = 1'b0;

  throttle_controller #(
    .ARM_FRAMES(3),
    .TIMEOUT_CYCLES(100),
    .SLEW_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_valid(frame_valid),
    .frame_crc_ok(frame_crc_ok),
    .frame_throttle(frame_throttle),
    .pwm_period_start(pwm_period_start),
    .target_speed(target_speed),
    .armed(armed),
    .failsafe(failsafe),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_cnt++;
    if (observed !== expected) begin
      error_cnt++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  // One clock edge; frame inputs fall back to idle and the PWM pulse is scheduled every 8 cycles.
  task automatic step();
    pwm_at_edge = pwm_period_start;
    @(posedge clk);
    #1;
    cyc++;
    frame_valid      = 1'b0;
    frame_crc_ok     = 1'b0;
    frame_throttle   = 8'd0;
    pwm_period_start = (cyc % 8 == 7);
  endtask

  task automatic applyStimulus(input logic [7:0] thr, input logic crc);
    frame_valid    = 1'b1;
    frame_crc_ok   = crc;
    frame_throttle = thr;
    step();
  endtask

  task automatic waitRamp(input logic [7:0] val, input int limit, output int n);
    n = 0;
    while (dut.ramp != val && n < limit) begin
      step();
      n++;
    end
    checkOutput("wait_ramp", 32'(dut.ramp), 32'(val));
  endtask

  task automatic waitPwm();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!pwm_at_edge && n < 10);
    checkOutput("wait_pwm", 32'(pwm_at_edge), 1);
  endtask

  initial begin
    int n;
    logic [7:0] prev_ts;
    rst_n = 1'b0;
    frame_valid = 1'b0;
    frame_crc_ok = 1'b0;
    frame_throttle = 8'd0;
    pwm_period_start = 1'b0;
    repeat (3) step();
    checkOutput("rst_state", 32'(state), 0);
    checkOutput("rst_ts", 32'(target_speed), 0);
    checkOutput("rst_armed", 32'(armed), 0);
    checkOutput("rst_failsafe", 32'(failsafe), 0);
    rst_n = 1'b1;
    step();

    // Arming abort, with a bad-CRC frame in the middle
    applyStimulus(8'd0, 1'b1);
    checkOutput("abort_arming", 32'(state), 1);
    repeat (5) step();
    applyStimulus(8'd0, 1'b1);
    checkOutput("abort_cnt2", 32'(dut.arm_cnt), 2);
    repeat (5) step();
    applyStimulus(8'd0, 1'b0);
    checkOutput("badcrc_cnt", 32'(dut.arm_cnt), 2);
    checkOutput("badcrc_wd", 32'(dut.wd_cnt), 6);
    checkOutput("badcrc_state", 32'(state), 1);
    applyStimulus(8'd50, 1'b1);
    checkOutput("abort_state", 32'(state), 0);
    checkOutput("abort_cnt0", 32'(dut.arm_cnt), 0);

    // Arming with frames 10 cycles apart
    applyStimulus(8'd0, 1'b1);
    checkOutput("arm_f1", 32'(state), 1);
    repeat (9) step();
    applyStimulus(8'd0, 1'b1);
    checkOutput("arm_f2", 32'(state), 1);
    checkOutput("arm_f2_ts", 32'(target_speed), 0);
    repeat (9) step();
    applyStimulus(8'd0, 1'b1);
    checkOutput("arm_f3", 32'(state), 2);
    checkOutput("arm_armed", 32'(armed), 1);
    checkOutput("arm_ts", 32'(target_speed), 0);

    // Slew up to 20; target_speed only changes after a period start
    applyStimulus(8'd20, 1'b1);
    checkOutput("cmd20", 32'(dut.cmd), 20);
    n = 0;
    while (dut.ramp != 8'd20 && n < 200) begin
      prev_ts = target_speed;
      step();
      n++;
      checkOutput("ts_gate", 32'(target_speed != prev_ts && !pwm_at_edge), 0);
      checkOutput("ramp_le_cmd", 32'(dut.ramp <= 8'd20), 1);
    end
    checkOutput("slew_up_cycles", 32'(n >= 77 && n <= 80), 1);
    waitPwm();
    checkOutput("ts20", 32'(target_speed), 20);

    // Immediate decrease to 5, presented at the next period start
    applyStimulus(8'd5, 1'b1);
    step();
    checkOutput("ramp_dec", 32'(dut.ramp), 5);
    checkOutput("ts_hold20", 32'(target_speed), 20);
    waitPwm();
    checkOutput("ts5", 32'(target_speed), 5);

    // Frame arriving exactly as the watchdog reaches 99
    applyStimulus(8'd20, 1'b1);
    repeat (99) step();
    checkOutput("wd99", 32'(dut.wd_cnt), 99);
    checkOutput("ramp20_again", 32'(dut.ramp), 20);
    applyStimulus(8'd20, 1'b1);
    checkOutput("race_state", 32'(state), 2);
    checkOutput("race_failsafe", 32'(failsafe), 0);
    checkOutput("race_wd", 32'(dut.wd_cnt), 0);

    // Failsafe after 100 silent cycles, then ramp down
    repeat (99) step();
    checkOutput("pre_fs_state", 32'(state), 2);
    step();
    checkOutput("fs_state", 32'(state), 3);
    checkOutput("fs_flag", 32'(failsafe), 1);
    checkOutput("fs_armed", 32'(armed), 0);
    checkOutput("fs_ts", 32'(target_speed), 20);
    repeat (8) step();
    checkOutput("fs_ramp18", 32'(dut.ramp), 18);
    applyStimulus(8'd0, 1'b1);
    checkOutput("fs_zero_early", 32'(state), 3);
    waitRamp(8'd0, 100, n);
    applyStimulus(8'd50, 1'b1);
    checkOutput("fs_nonzero", 32'(state), 3);
    applyStimulus(8'd0, 1'b1);
    checkOutput("fs_exit_state", 32'(state), 0);
    checkOutput("fs_exit_flag", 32'(failsafe), 0);
    checkOutput("fs_exit_ts", 32'(target_speed), 0);

    // Reset while armed at speed 20
    repeat (3) applyStimulus(8'd0, 1'b1);
    checkOutput("rearm", 32'(state), 2);
    applyStimulus(8'd20, 1'b1);
    waitRamp(8'd20, 100, n);
    waitPwm();
    checkOutput("pre_rst_ts", 32'(target_speed), 20);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checkOutput("mid_rst_state", 32'(state), 0);
    checkOutput("mid_rst_ts", 32'(target_speed), 0);
    checkOutput("mid_rst_armed", 32'(armed), 0);
    checkOutput("mid_rst_failsafe", 32'(failsafe), 0);
    checkOutput("mid_rst_ramp", 32'(dut.ramp), 0);
    checkOutput("mid_rst_wd", 32'(dut.wd_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
